// File: rtl/ecpri_pkg.sv
// Shared types and default widths for the eCPRI receive packet buffer.
package ecpri_pkg;

    localparam int ECPRI_DATA_W    = 8;
    localparam int ECPRI_ADDR_W    = 11;
    localparam int ECPRI_DESC_LOG2 = 3;
    localparam int ECPRI_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [ECPRI_ADDR_W-1:0] start;
        logic [ECPRI_ADDR_W:0]   len;
    } ecpri_desc_t;

endpackage

// File: rtl/pkt_buf_ram.sv
// Simple 1W1R synchronous RAM; read port is registered and read-first.
module pkt_buf_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ecpri_pkt_buf.sv
// Receive packet buffer: stores whole frames in a circular RAM and queues
// one descriptor per committed frame; oversize or unqueueable frames are dropped.
module ecpri_pkt_buf
    import ecpri_pkg::*;
#(
    parameter int DATA_WIDTH = ECPRI_DATA_W,
    parameter int ADDR_WIDTH = ECPRI_ADDR_W,
    parameter int DESC_LOG2  = ECPRI_DESC_LOG2,
    parameter int CNT_WIDTH  = ECPRI_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] inp_data_fifo,
    input  logic                  recv_pkt,
    input  logic                  recv_eop,
    output logic                  pkt_avail,
    output logic [ADDR_WIDTH:0]   pkt_len,
    input  logic                  pkt_pop,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_offset,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   free_words,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam logic [ADDR_WIDTH:0] FULL_SPACE = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_LEN    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] start;
        logic [ADDR_WIDTH:0]   len;
    } desc_t;

    wr_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_wr_base;
    logic [ADDR_WIDTH:0]   r_cur_len;
    logic [ADDR_WIDTH:0]   r_free;
    logic [CNT_WIDTH-1:0]  r_drop;
    desc_t                 r_desc [0:(1<<DESC_LOG2)-1];
    logic [DESC_LOG2-1:0]  r_wptr;
    logic [DESC_LOG2-1:0]  r_rptr;
    logic [DESC_LOG2:0]    r_count;

    wr_state_t             w_state_nxt;
    logic [ADDR_WIDTH:0]   w_cur_len_nxt;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic                  w_commit;
    logic [ADDR_WIDTH:0]   w_commit_len;
    logic                  w_drop_done;
    logic                  w_avail;
    logic                  w_q_full;
    logic                  w_pop;
    desc_t                 w_head;
    logic [ADDR_WIDTH-1:0] w_head_start;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH:0]   w_sub;
    logic [ADDR_WIDTH:0]   w_add;

    // Count never exceeds the queue depth, so its MSB alone flags "full".
    assign w_avail  = (r_count != '0);
    assign w_q_full = r_count[DESC_LOG2];
    assign w_pop    = pkt_pop && w_avail;
    assign w_head   = r_desc[r_rptr];

    // With nothing queued, the next frame will start at wr_base.
    assign w_head_start = w_avail ? w_head.start : r_wr_base;
    assign w_raddr      = w_head_start + rd_offset;

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_len_nxt = r_cur_len;
        w_we          = 1'b0;
        w_waddr       = r_wr_base;
        w_commit      = 1'b0;
        w_commit_len  = r_cur_len + ONE_LEN;
        w_drop_done   = 1'b0;
        case (r_state)
            ST_IDLE: if (recv_pkt) begin
                if (w_q_full || (r_free == '0)) begin
                    if (recv_eop) w_drop_done = 1'b1;
                    else          w_state_nxt = ST_DROP;
                end else begin
                    w_we = 1'b1;
                    if (recv_eop) begin
                        w_commit     = 1'b1;
                        w_commit_len = ONE_LEN;
                    end else begin
                        w_cur_len_nxt = ONE_LEN;
                        w_state_nxt   = ST_RECV;
                    end
                end
            end
            ST_RECV: if (recv_pkt) begin
                if (r_cur_len == r_free) begin
                    if (recv_eop) begin
                        w_drop_done = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end else begin
                    w_we    = 1'b1;
                    w_waddr = r_wr_base + r_cur_len[ADDR_WIDTH-1:0];
                    if (recv_eop) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cur_len_nxt = r_cur_len + ONE_LEN;
                    end
                end
            end
            ST_DROP: if (recv_pkt && recv_eop) begin
                w_drop_done = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sub = w_commit ? w_commit_len : '0;
    assign w_add = w_pop ? w_head.len : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_wr_base <= '0;
            r_cur_len <= '0;
            r_free    <= FULL_SPACE;
            r_drop    <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_len <= w_cur_len_nxt;
            r_free    <= r_free - w_sub + w_add;
            if (w_commit) begin
                r_wr_base <= r_wr_base + w_commit_len[ADDR_WIDTH-1:0];
                r_wptr    <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_commit, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop_done && (r_drop != '1)) r_drop <= r_drop + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) r_desc[r_wptr] <= '{start: r_wr_base, len: w_commit_len};
    end

    pkt_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (inp_data_fifo),
        .i_re    (rd_en),
        .i_raddr (w_raddr),
        .o_rdata (rd_data)
    );

    assign pkt_avail  = w_avail;
    assign pkt_len    = w_avail ? w_head.len : '0;
    assign free_words = r_free;
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_ecpri_pkt_buf.sv
// Directed bench for ecpri_pkt_buf: framing, wrap, overflow, queue-full, pop/commit overlap, reset.
module tb_ecpri_pkt_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  inp_data_fifo = '0;
    logic        recv_pkt = 1'b0;
    logic        recv_eop = 1'b0;
    logic        pkt_avail;
    logic [11:0] pkt_len;
    logic        pkt_pop = 1'b0;
    logic        rd_en = 1'b0;
    logic [10:0] rd_offset = '0;
    logic [7:0]  rd_data;
    logic [11:0] free_words;
    logic [15:0] drop_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] d;

    always #5 clk = ~clk;

    ecpri_pkt_buf #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (11),
        .DESC_LOG2  (3),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inp_data_fifo (inp_data_fifo),
        .recv_pkt      (recv_pkt),
        .recv_eop      (recv_eop),
        .pkt_avail     (pkt_avail),
        .pkt_len       (pkt_len),
        .pkt_pop       (pkt_pop),
        .rd_en         (rd_en),
        .rd_offset     (rd_offset),
        .rd_data       (rd_data),
        .free_words    (free_words),
        .drop_cnt      (drop_cnt)
    );

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Word i of a frame carries (seed + i) mod 256.
    task automatic send_frame(input int len, input int seed, input bit pop_at_eop);
        for (int i = 0; i < len; i++) begin
            inp_data_fifo = 8'((seed + i) & 255);
            recv_pkt      = 1'b1;
            recv_eop      = (i == len - 1);
            pkt_pop       = pop_at_eop && (i == len - 1);
            @(negedge clk);
        end
        recv_pkt = 1'b0;
        recv_eop = 1'b0;
        pkt_pop  = 1'b0;
    endtask

    task automatic do_read(input int off, output logic [7:0] data);
        rd_en     = 1'b1;
        rd_offset = 11'(off);
        @(negedge clk);
        rd_en = 1'b0;
        data  = rd_data;
    endtask

    task automatic do_pop();
        pkt_pop = 1'b1;
        @(negedge clk);
        pkt_pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (pkt_avail !== 1'b0) $display("FAIL rst_avail: got %0d want 0", pkt_avail); else n_pass++;
        n_total++; if (pkt_len !== 12'd0) $display("FAIL rst_len: got %0d want 0", pkt_len); else n_pass++;
        n_total++; if (rd_data !== 8'h00) $display("FAIL rst_rd_data: got %0h want 0", rd_data); else n_pass++;
        n_total++; if (free_words !== 12'd2048) $display("FAIL rst_free: got %0d want 2048", free_words); else n_pass++;
        n_total++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d want 0", drop_cnt); else n_pass++;
    endtask

    task automatic test_single_frame();
        send_frame(64, 0, 1'b0);
        n_total++; if (pkt_avail !== 1'b1) $display("FAIL single_avail: got %0d want 1", pkt_avail); else n_pass++;
        n_total++; if (pkt_len !== 12'd64) $display("FAIL single_len: got %0d want 64", pkt_len); else n_pass++;
        n_total++; if (free_words !== 12'd1984) $display("FAIL single_free: got %0d want 1984", free_words); else n_pass++;
        do_read(10, d);
        n_total++; if (d !== 8'd10) $display("FAIL single_rd10: got %0d want 10", d); else n_pass++;
        do_read(63, d);
        @(negedge clk);
        n_total++; if (rd_data !== 8'd63) $display("FAIL single_rd_hold: got %0d want 63", rd_data); else n_pass++;
        do_pop();
        n_total++; if (pkt_avail !== 1'b0) $display("FAIL single_pop_avail: got %0d want 0", pkt_avail); else n_pass++;
    endtask

    task automatic test_one_word();
        send_frame(1, 8'hA5, 1'b0);
        n_total++; if (pkt_len !== 12'd1) $display("FAIL oneword_len: got %0d want 1", pkt_len); else n_pass++;
        n_total++; if (free_words !== 12'd2047) $display("FAIL oneword_free: got %0d want 2047", free_words); else n_pass++;
        do_read(0, d);
        n_total++; if (d !== 8'hA5) $display("FAIL oneword_rd: got %0h want a5", d); else n_pass++;
        do_pop();
        n_total++; if (pkt_avail !== 1'b0) $display("FAIL oneword_pop_avail: got %0d want 0", pkt_avail); else n_pass++;
        n_total++; if (free_words !== 12'd2048) $display("FAIL oneword_pop_free: got %0d want 2048", free_words); else n_pass++;
        n_total++; if (pkt_len !== 12'd0) $display("FAIL oneword_pop_len: got %0d want 0", pkt_len); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        send_frame(2000, 0, 1'b0);
        n_total++; if (free_words !== 12'd48) $display("FAIL wrap_free_2000: got %0d want 48", free_words); else n_pass++;
        do_pop();
        send_frame(100, 8'h40, 1'b0);
        n_total++; if (pkt_len !== 12'd100) $display("FAIL wrap_len: got %0d want 100", pkt_len); else n_pass++;
        n_total++; if (free_words !== 12'd1948) $display("FAIL wrap_free: got %0d want 1948", free_words); else n_pass++;
        do_read(47, d);
        n_total++; if (d !== 8'h6F) $display("FAIL wrap_rd47: got %0h want 6f", d); else n_pass++;
        do_read(48, d);
        n_total++; if (d !== 8'h70) $display("FAIL wrap_rd48: got %0h want 70", d); else n_pass++;
        do_read(99, d);
        n_total++; if (d !== 8'hA3) $display("FAIL wrap_rd99: got %0h want a3", d); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        send_frame(1500, 3, 1'b0);
        send_frame(600, 8'h80, 1'b0);
        n_total++; if (drop_cnt !== 16'd1) $display("FAIL ovf_drop: got %0d want 1", drop_cnt); else n_pass++;
        n_total++; if (free_words !== 12'd548) $display("FAIL ovf_free: got %0d want 548", free_words); else n_pass++;
        n_total++; if (pkt_avail !== 1'b1) $display("FAIL ovf_avail: got %0d want 1", pkt_avail); else n_pass++;
        n_total++; if (pkt_len !== 12'd1500) $display("FAIL ovf_len: got %0d want 1500", pkt_len); else n_pass++;
        do_read(0, d);
        n_total++; if (d !== 8'd3) $display("FAIL ovf_rd0: got %0d want 3", d); else n_pass++;
        do_read(700, d);
        n_total++; if (d !== 8'd191) $display("FAIL ovf_rd700: got %0d want 191", d); else n_pass++;
        do_read(1499, d);
        n_total++; if (d !== 8'd222) $display("FAIL ovf_rd1499: got %0d want 222", d); else n_pass++;
    endtask

    task automatic test_desc_full();
        do_reset();
        for (int k = 0; k < 8; k++) send_frame(4, k * 16, 1'b0);
        n_total++; if (free_words !== 12'd2016) $display("FAIL full_free8: got %0d want 2016", free_words); else n_pass++;
        send_frame(4, 8'h80, 1'b0);
        n_total++; if (drop_cnt !== 16'd1) $display("FAIL full_drop: got %0d want 1", drop_cnt); else n_pass++;
        n_total++; if (free_words !== 12'd2016) $display("FAIL full_free9: got %0d want 2016", free_words); else n_pass++;
        do_pop();
        n_total++; if (free_words !== 12'd2020) $display("FAIL full_free_pop: got %0d want 2020", free_words); else n_pass++;
        send_frame(4, 8'h90, 1'b0);
        n_total++; if (drop_cnt !== 16'd1) $display("FAIL full_drop10: got %0d want 1", drop_cnt); else n_pass++;
        do_read(0, d);
        n_total++; if (d !== 8'h10) $display("FAIL full_head_rd: got %0h want 10", d); else n_pass++;
        repeat (7) do_pop();
        n_total++; if (pkt_avail !== 1'b1) $display("FAIL full_avail7: got %0d want 1", pkt_avail); else n_pass++;
        n_total++; if (pkt_len !== 12'd4) $display("FAIL full_len7: got %0d want 4", pkt_len); else n_pass++;
        do_read(2, d);
        n_total++; if (d !== 8'h92) $display("FAIL full_rd10th: got %0h want 92", d); else n_pass++;
        do_pop();
        n_total++; if (pkt_avail !== 1'b0) $display("FAIL full_avail8: got %0d want 0", pkt_avail); else n_pass++;
        n_total++; if (free_words !== 12'd2048) $display("FAIL full_free_end: got %0d want 2048", free_words); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(10, 0, 1'b0);
        n_total++; if (free_words !== 12'd2038) $display("FAIL b2b_free_a: got %0d want 2038", free_words); else n_pass++;
        send_frame(20, 8'h30, 1'b1);
        n_total++; if (free_words !== 12'd2028) $display("FAIL b2b_free: got %0d want 2028", free_words); else n_pass++;
        n_total++; if (pkt_len !== 12'd20) $display("FAIL b2b_len: got %0d want 20", pkt_len); else n_pass++;
        do_read(5, d);
        n_total++; if (d !== 8'h35) $display("FAIL b2b_rd: got %0h want 35", d); else n_pass++;
        do_pop();
        n_total++; if (pkt_avail !== 1'b0) $display("FAIL b2b_avail: got %0d want 0", pkt_avail); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_frame(6, 8'h11, 1'b0);
        do_read(2, d);
        n_total++; if (d !== 8'h13) $display("FAIL rmid_pre_rd: got %0h want 13", d); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            inp_data_fifo = 8'(8'hC0 + i);
            recv_pkt      = 1'b1;
            @(negedge clk);
        end
        recv_pkt = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        n_total++; if (pkt_avail !== 1'b0) $display("FAIL rmid_avail: got %0d want 0", pkt_avail); else n_pass++;
        n_total++; if (pkt_len !== 12'd0) $display("FAIL rmid_len: got %0d want 0", pkt_len); else n_pass++;
        n_total++; if (free_words !== 12'd2048) $display("FAIL rmid_free: got %0d want 2048", free_words); else n_pass++;
        n_total++; if (drop_cnt !== 16'd0) $display("FAIL rmid_drop: got %0d want 0", drop_cnt); else n_pass++;
        n_total++; if (rd_data !== 8'h00) $display("FAIL rmid_rd_data: got %0h want 0", rd_data); else n_pass++;
        send_frame(3, 8'h21, 1'b0);
        n_total++; if (pkt_len !== 12'd3) $display("FAIL rmid_new_len: got %0d want 3", pkt_len); else n_pass++;
        do_read(0, d);
        n_total++; if (d !== 8'h21) $display("FAIL rmid_new_rd: got %0h want 21", d); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_one_word();
        test_wrap();
        test_overflow();
        test_desc_full();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
